// File: rtl/sum_controller_pkg.sv
// Shared definitions for the sum_controller FSM: state codes, ALU/shifter opcodes,
// default register-file addresses and the packed control-word layout.
package sum_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INPUT = 3'd1,
    S_CLEAR = 3'd2,
    S_TEST  = 3'd3,
    S_ADD   = 3'd4,
    S_DEC   = 3'd5,
    S_OUT   = 3'd6
  } state_e;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_DEC   = 3'b111;

  localparam logic [1:0] SH_PASS = 2'b00;

  localparam logic [1:0] SUM_ADDR_DEFAULT = 2'b00;
  localparam logic [1:0] N_ADDR_DEFAULT   = 2'b01;

  // Field order matches the data_path control word {IE,WE,WA,RAE,RAA,RBE,RBA,ALU,SH,OE}.
  typedef struct packed {
    logic       ie;
    logic       we;
    logic [1:0] wa;
    logic       rae;
    logic [1:0] raa;
    logic       rbe;
    logic [1:0] rba;
    logic [2:0] alu;
    logic [1:0] sh;
    logic       oe;
  } ctrl_word_t;

endpackage

// File: rtl/sum_controller_rom.sv
// Combinational map from FSM state code to the 16-bit data_path control word.
// Unused state codes decode to an all-zero word.
module sum_controller_rom
  import sum_controller_pkg::*;
#(
  parameter logic [1:0] SUM_ADDR = SUM_ADDR_DEFAULT,
  parameter logic [1:0] N_ADDR   = N_ADDR_DEFAULT
) (
  input  state_e     state_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch.
    ctrl_o    = '0;
    ctrl_o.sh = SH_PASS;
    case (state_i)
      S_INPUT: begin
        ctrl_o.ie = 1'b1;
        ctrl_o.we = 1'b1;
        ctrl_o.wa = N_ADDR;
      end
      S_CLEAR: begin
        // sum <- sum - sum zeroes the accumulator without a dedicated clear path.
        ctrl_o.we  = 1'b1;
        ctrl_o.wa  = SUM_ADDR;
        ctrl_o.rae = 1'b1;
        ctrl_o.raa = SUM_ADDR;
        ctrl_o.rbe = 1'b1;
        ctrl_o.rba = SUM_ADDR;
        ctrl_o.alu = ALU_SUB;
      end
      S_TEST: begin
        ctrl_o.rae = 1'b1;
        ctrl_o.raa = N_ADDR;
        ctrl_o.alu = ALU_PASSA;
      end
      S_ADD: begin
        ctrl_o.we  = 1'b1;
        ctrl_o.wa  = SUM_ADDR;
        ctrl_o.rae = 1'b1;
        ctrl_o.raa = SUM_ADDR;
        ctrl_o.rbe = 1'b1;
        ctrl_o.rba = N_ADDR;
        ctrl_o.alu = ALU_ADD;
      end
      S_DEC: begin
        ctrl_o.we  = 1'b1;
        ctrl_o.wa  = N_ADDR;
        ctrl_o.rae = 1'b1;
        ctrl_o.raa = N_ADDR;
        ctrl_o.alu = ALU_DEC;
      end
      S_OUT: begin
        ctrl_o.rae = 1'b1;
        ctrl_o.raa = SUM_ADDR;
        ctrl_o.alu = ALU_PASSA;
        ctrl_o.oe  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/sum_controller.sv
// Moore FSM sequencing the data_path to compute n + (n-1) + ... + 1 (mod 256).
// Optional SUM_ITER_COUNT_EN adds a saturating iter_count of ADD cycles.
module sum_controller
  import sum_controller_pkg::*;
#(
  parameter logic [1:0] SUM_ADDR = SUM_ADDR_DEFAULT,
  parameter logic [1:0] N_ADDR   = N_ADDR_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       n_is_0,
  output logic       IE,
  output logic       WE,
  output logic [1:0] WA,
  output logic       RAE,
  output logic [1:0] RAA,
  output logic       RBE,
  output logic [1:0] RBA,
  output logic [2:0] ALU,
  output logic [1:0] SH,
  output logic       OE,
  output logic       busy,
  output logic       done
`ifdef SUM_ITER_COUNT_EN
  ,
  output logic [7:0] iter_count
`endif
);

  state_e     state_q, state_d;
  ctrl_word_t ctrl;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INPUT;
      S_INPUT: state_d = S_CLEAR;
      S_CLEAR: state_d = S_TEST;
      S_TEST:  state_d = n_is_0 ? S_OUT : S_ADD;
      S_ADD:   state_d = S_DEC;
      S_DEC:   state_d = S_TEST;
      // Holding start in OUT keeps the result; a new request needs a pass through IDLE.
      S_OUT:   if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  sum_controller_rom #(
    .SUM_ADDR(SUM_ADDR),
    .N_ADDR  (N_ADDR)
  ) u_rom (
    .state_i(state_q),
    .ctrl_o (ctrl)
  );

  assign {IE, WE, WA, RAE, RAA, RBE, RBA, ALU, SH, OE} = ctrl;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_OUT);

`ifdef SUM_ITER_COUNT_EN
  logic [7:0] iter_q, iter_d;

  always_comb begin
    iter_d = iter_q;
    if (state_q == S_INPUT)                     iter_d = 8'd0;
    else if (state_q == S_ADD && iter_q != 8'hFF) iter_d = iter_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) iter_q <= 8'd0;
    else       iter_q <= iter_d;
  end

  assign iter_count = iter_q;
`endif

endmodule

// File: tb/tb_sum_controller.sv
// Scoreboard bench for sum_controller driving a behavioural data_path; checks
// result, latency and (with SUM_ITER_COUNT_EN) iter_count per transaction.
module tb_sum_controller;

  localparam int HALF = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       n_is_0;
  logic       IE, WE, RAE, RBE, OE, busy, done;
  logic [1:0] WA, RAA, RBA, SH;
  logic [2:0] ALU;
  logic [7:0] n_input;
`ifdef SUM_ITER_COUNT_EN
  logic [7:0] iter_count;
`endif

  always #HALF clock = ~clock;

  sum_controller dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .n_is_0(n_is_0),
    .IE    (IE),
    .WE    (WE),
    .WA    (WA),
    .RAE   (RAE),
    .RAA   (RAA),
    .RBE   (RBE),
    .RBA   (RBA),
    .ALU   (ALU),
    .SH    (SH),
    .OE    (OE),
    .busy  (busy),
    .done  (done)
`ifdef SUM_ITER_COUNT_EN
    ,
    .iter_count(iter_count)
`endif
  );

  // Behavioural data_path: 4x8 register file, ALU, zero flag.
  logic [7:0] rf [4];
  logic [7:0] op_a, op_b, alu_out, wbus;

  always_comb begin
    op_a = RAE ? rf[RAA] : 8'd0;
    op_b = RBE ? rf[RBA] : 8'd0;
    case (ALU)
      3'b000:  alu_out = op_a;
      3'b100:  alu_out = op_a + op_b;
      3'b101:  alu_out = op_a - op_b;
      3'b111:  alu_out = op_a - 8'd1;
      default: alu_out = 8'd0;
    endcase
    wbus = IE ? n_input : alu_out;
  end

  assign n_is_0 = (alu_out == 8'd0);

  always @(posedge clock) if (WE) rf[WA] <= wbus;

  initial for (int i = 0; i < 4; i++) rf[i] = 8'd0;

  typedef struct {
    int result;
    int latency;
    int iters;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    e.result  = ((n * (n + 1)) / 2) % 256;
    e.latency = 3 * n + 3;
    e.iters   = (n > 255) ? 255 : n;
    return e;
  endfunction

  function automatic int ctrl_word();
    logic [15:0] cw;
    cw = {IE, WE, WA, RAE, RAA, RBE, RBA, ALU, SH, OE};
    return int'(cw);
  endfunction

  // Monitor: measures cycles from INPUT entry to done and pops the scoreboard.
  initial begin
    exp_t e;
    int   cyc = 0;
    int   t_in = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (busy && !busy_prev) t_in = cyc;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", int'(alu_out), e.result);
          check("latency", cyc - t_in, e.latency);
          check("oe_at_done", int'(OE), 1);
`ifdef SUM_ITER_COUNT_EN
          check("iter_count", int'(iter_count), e.iters);
`endif
        end
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  task automatic issue(input int n);
    n_input = n[7:0];
    start   = 1'b1;
    exp_q.push_back(model(n));
  endtask

  task automatic finish_txn();
    int k = 0;
    while (!done && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      start = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    repeat (2) begin
      @(negedge clock);
      check("hold_done", int'(done), 1);
    end
    start = 1'b0;
    @(negedge clock);
    check("idle_busy", int'(busy), 0);
    check("idle_ctrl", ctrl_word(), 0);
  endtask

  initial begin
    int k;
    int fixed_n[6] = '{5, 0, 23, 255, 7, 1};

    reset   = 1'b1;
    start   = 1'b1;
    n_input = 8'd3;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ctrl", ctrl_word(), 0);

    exp_q.push_back(model(3));
    reset = 1'b0;
    @(negedge clock);
    check("input_ie", int'(IE), 1);
    check("input_busy", int'(busy), 1);
    finish_txn();

    foreach (fixed_n[i]) begin
      issue(fixed_n[i]);
      finish_txn();
    end

    // Abort during an ADD cycle of n=10.
    issue(10);
    k = 0;
    while (ALU !== 3'b100 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("reach_add", int'(ALU), 4);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    check("abort_busy", int'(busy), 0);
    check("abort_ctrl", ctrl_word(), 0);
`ifdef SUM_ITER_COUNT_EN
    check("abort_iter", int'(iter_count), 0);
`endif
    void'(exp_q.pop_front());
    reset = 1'b0;
    @(negedge clock);

    issue(10);
    finish_txn();

    repeat (6) begin
      issue(int'($urandom_range(0, 60)));
      finish_txn();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
